paddle_pair_view: RTL and testbench
===================================

Name: paddle_pair_view

Overview:
- Vector renderer for both Pong paddles on the XY oscilloscope output.
- Alternates between the left paddle (fixed X_LEFT) and the right paddle (fixed X_RIGHT). Each paddle is drawn as a vertical run of points.
- Half-width, per-point dwell and Y step are runtime or parameter controlled, and the block emits segment/frame strobes.
- Sits between game logic (paddle centres) and the XY DAC mux; beam_on gates the Z/blank input.

Parameters:
- COORD_W, 8, coordinate width for x_out, y_out, y_mid_l, y_mid_r.
- Y_MAX, 220, exclusive upper Y clamp (last drawable y is Y_MAX-1).
- X_LEFT, 0, X coordinate of left paddle.
- X_RIGHT, 255, X coordinate of right paddle.
- HW_W, 6, width of half_w input.
- DWELL_W, 4, width of dwell input.
- Y_STEP, 1, Y increment between drawn points (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  run enable
- y_mid_l  in  COORD_W  left paddle centre
- y_mid_r  in  COORD_W  right paddle centre
- half_w  in  HW_W  paddle half-width in pixels
- dwell  in  DWELL_W  extra hold cycles per point (each point is held dwell+1 cycles)
- x_out  out  COORD_W  beam X
- y_out  out  COORD_W  beam Y
- beam_on  out  1  beam visible (1 only while drawing a point)
- side  out  1  0 = left segment active, 1 = right
- seg_done  out  1  one-cycle pulse on the last cycle of each segment
- frame_done  out  1  one-cycle pulse on the last cycle of the right segment

Behaviour:
- Reset values: state IDLE, x_out=X_LEFT, y_out=0, beam_on=0, side=0, seg_done=0, frame_done=0. Reset wins over all other inputs, including mid-segment.
- States: IDLE, LOAD, DRAW.
- IDLE:
  - beam_on=0.
  - If en=1, go to LOAD with side=0.
- LOAD (1 cycle, beam_on=0):
  - Sample mid (y_mid_l or y_mid_r per side), half_w and dwell into registers.
  - Set x_out to X_LEFT or X_RIGHT.
  - Compute bounds:
    - midc = min(mid, Y_MAX).
    - y_min = (midc >= half_w) ? midc-half_w : 0.
    - y_max = (midc+half_w <= Y_MAX) ? midc+half_w : Y_MAX.
    - Compute the sum in COORD_W+1 bits; no wrap allowed.
  - Set y_out=y_min, then go to DRAW.
- DRAW:
  - beam_on=1.
  - Hold y_out for dwell+1 cycles, then advance y_out by Y_STEP.
  - Last point: the final point is the last one with y_out < y_max.
  - Degenerate case: if y_max == y_min, draw exactly one point at y_min.
  - Next-point test uses COORD_W+1 bits (y_out+Y_STEP >= y_max ends the segment); no wrap past 255.
  - On the final hold cycle of the final point, assert seg_done. If side=1, also assert frame_done.
  - Next state after the final cycle:
    - side=0: LOAD with side=1.
    - side=1 and en=1: LOAD with side=0.
    - side=1 and en=0: IDLE.
  - en=0 during a left segment: the left segment completes, then goes to IDLE (no right segment).
  - en changes never truncate a segment.
- Latched values: inputs changing during DRAW have no effect until the next LOAD.
- Segment length in cycles: 1 + N*(dwell+1), where N = max(1, ceil((y_max-y_min)/Y_STEP)).
- Outputs are registered; y_out/x_out are valid in the same cycle as beam_on.

Test Plan:
- Nominal: defaults, half_w=21, y_mid_l=100, y_mid_r=150, dwell=0, en=1 → LOAD, then x=0 with y 79..120 (42 cycles, beam_on=1), seg_done on y=120. Then LOAD, then x=255 with y 129..170, seg_done and frame_done on y=170. Frame is 86 cycles, then repeats.
- Clamping:
  - mid=10, hw=21 → y 0..30 (31 points).
  - mid=210 → y 189..219.
  - mid=250 → treated as 220 → y 199..219.
  - y_out never reaches 220.
- Degenerate and dwell:
  - half_w=0, mid=50 → single point y=50 for 1 cycle.
  - dwell=3, hw=2, mid=100 → y 98,99,100,101, each held 4 cycles; segment is 17 cycles.
- Step: Y_STEP=2, hw=21, mid=100 → y 79,81,...,119 (21 points), seg_done on y=119.
- Control:
  - en dropped mid-left-segment → left segment finishes with seg_done, frame_done=0, then IDLE with beam_on=0 and no right segment.
  - y_mid_l changed mid-DRAW → current segment is unchanged.
- Reset: rst asserted during DRAW at y=90 → next cycle shows reset values (x=X_LEFT, y=0, beam_on=0, side=0). After rst release with en=1, drawing restarts with LOAD on the left.

Source files
------------

// File: rtl/paddle_pair_view.sv
// Draws both Pong paddles as vertical point runs on the XY scope, left then right.
// One LOAD cycle per segment, then dwell+1 cycles per point; free-running, no backpressure.
module paddle_pair_view #(
  parameter int COORD_W = 8,
  parameter int Y_MAX   = 220,
  parameter int X_LEFT  = 0,
  parameter int X_RIGHT = 255,
  parameter int HW_W    = 6,
  parameter int DWELL_W = 4,
  parameter int Y_STEP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [COORD_W-1:0] y_mid_l,
  input  logic [COORD_W-1:0] y_mid_r,
  input  logic [HW_W-1:0]    half_w,
  input  logic [DWELL_W-1:0] dwell,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               beam_on,
  output logic               side,
  output logic               seg_done,
  output logic               frame_done
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [COORD_W:0] YMAX_E = CW1'(Y_MAX);
  localparam logic [COORD_W:0] STEP_E = CW1'(Y_STEP);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW} state_t;

  state_t             state, state_n;
  logic [COORD_W-1:0] x_n, y_n, y_max_r, y_max_n;
  logic [DWELL_W-1:0] dwell_r, dwell_n, cnt_r, cnt_n, cnt_inc;
  logic               beam_n, side_n, seg_n, frame_n;

  logic [COORD_W-1:0] mid_sel;
  logic [COORD_W:0]   mid_e, midc, hw_e, sum_e, lo_e, hi_e, lo_step_e;
  logic [COORD_W:0]   y_next_e, y_next2_e;
  logic               last_pt;

  // Bound arithmetic is one bit wider than the coordinates so nothing wraps.
  always_comb begin
    mid_sel   = side ? y_mid_r : y_mid_l;
    mid_e     = {1'b0, mid_sel};
    midc      = (mid_e > YMAX_E) ? YMAX_E : mid_e;
    hw_e      = CW1'(half_w);
    sum_e     = midc + hw_e;
    lo_e      = (midc >= hw_e) ? (midc - hw_e) : '0;
    hi_e      = (sum_e <= YMAX_E) ? sum_e : YMAX_E;
    lo_step_e = lo_e + STEP_E;
    y_next_e  = {1'b0, y_out} + STEP_E;
    y_next2_e = y_next_e + STEP_E;
    last_pt   = (y_next_e >= {1'b0, y_max_r});
    cnt_inc   = cnt_r + DWELL_W'(1);
  end

  // seg_done is computed one cycle ahead so it lands registered on the final hold cycle.
  always_comb begin
    state_n = state;
    x_n     = x_out;
    y_n     = y_out;
    beam_n  = beam_on;
    side_n  = side;
    seg_n   = 1'b0;
    frame_n = 1'b0;
    y_max_n = y_max_r;
    dwell_n = dwell_r;
    cnt_n   = cnt_r;
    case (state)
      IDLE: begin
        beam_n = 1'b0;
        side_n = 1'b0;
        if (en) state_n = LOAD;
      end
      LOAD: begin
        x_n     = side ? COORD_W'(X_RIGHT) : COORD_W'(X_LEFT);
        y_n     = lo_e[COORD_W-1:0];
        y_max_n = hi_e[COORD_W-1:0];
        dwell_n = dwell;
        cnt_n   = '0;
        beam_n  = 1'b1;
        state_n = DRAW;
        seg_n   = (dwell == '0) && (lo_step_e >= hi_e);
        frame_n = seg_n && side;
      end
      DRAW: begin
        if (seg_done) begin
          beam_n = 1'b0;
          if (en) begin
            state_n = LOAD;
            side_n  = ~side;
          end else begin
            // Dropping en after the left segment skips the right one.
            state_n = IDLE;
            side_n  = 1'b0;
          end
        end else if (cnt_r == dwell_r) begin
          y_n     = y_next_e[COORD_W-1:0];
          cnt_n   = '0;
          seg_n   = (dwell_r == '0) && (y_next2_e >= {1'b0, y_max_r});
          frame_n = seg_n && side;
        end else begin
          cnt_n   = cnt_inc;
          seg_n   = (cnt_inc == dwell_r) && last_pt;
          frame_n = seg_n && side;
        end
      end
      default: begin
        state_n = IDLE;
        beam_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      x_out      <= COORD_W'(X_LEFT);
      y_out      <= '0;
      beam_on    <= 1'b0;
      side       <= 1'b0;
      seg_done   <= 1'b0;
      frame_done <= 1'b0;
      y_max_r    <= '0;
      dwell_r    <= '0;
      cnt_r      <= '0;
    end else begin
      state      <= state_n;
      x_out      <= x_n;
      y_out      <= y_n;
      beam_on    <= beam_n;
      side       <= side_n;
      seg_done   <= seg_n;
      frame_done <= frame_n;
      y_max_r    <= y_max_n;
      dwell_r    <= dwell_n;
      cnt_r      <= cnt_n;
    end
  end

endmodule

// File: tb/tb_paddle_pair_view.sv
// Directed bench: default-step instance plus a Y_STEP=2 instance sharing the same inputs.
module tb_paddle_pair_view;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [7:0] y_mid_l, y_mid_r;
  logic [5:0] half_w;
  logic [3:0] dwell;

  logic [7:0] x1, y1, x2, y2;
  logic       b1, s1, sd1, fd1, b2, s2, sd2, fd2;
  logic [7:0] xo, yo;
  logic       bo, so, sdo, fdo;

  int total = 0;
  int bad   = 0;
  int sel   = 0;
  int max_y = 0;
  int nx_l, nx_r, nx_hw, nx_dw, nx_en;

  always #5 clk = ~clk;

  paddle_pair_view dut (
    .clk(clk), .rst(rst), .en(en), .y_mid_l(y_mid_l), .y_mid_r(y_mid_r),
    .half_w(half_w), .dwell(dwell), .x_out(x1), .y_out(y1), .beam_on(b1),
    .side(s1), .seg_done(sd1), .frame_done(fd1)
  );

  paddle_pair_view #(.Y_STEP(2)) dut_s2 (
    .clk(clk), .rst(rst), .en(en), .y_mid_l(y_mid_l), .y_mid_r(y_mid_r),
    .half_w(half_w), .dwell(dwell), .x_out(x2), .y_out(y2), .beam_on(b2),
    .side(s2), .seg_done(sd2), .frame_done(fd2)
  );

  always_comb begin
    if (sel == 1) begin
      xo = x2; yo = y2; bo = b2; so = s2; sdo = sd2; fdo = fd2;
    end else begin
      xo = x1; yo = y1; bo = b1; so = s1; sdo = sd1; fdo = fd1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_x"}, xo, 0);
    check({tag, "_y"}, yo, 0);
    check({tag, "_beam"}, bo, 0);
    check({tag, "_side"}, so, 0);
    check({tag, "_seg"}, sdo, 0);
    check({tag, "_frame"}, fdo, 0);
  endtask

  task automatic wait_beam(input string tag, input int exp_lat);
    int n = 0;
    while (bo !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check(tag, n, exp_lat);
  endtask

  // Walks one segment point by point; at cycle poke_at the nx_* inputs are applied.
  task automatic seg(input string tag, input int ex_x, input int y0, input int npts,
                     input int stp, input int dw, input int sd, input int poke_at);
    int c = 0;
    for (int p = 0; p < npts; p++) begin
      for (int h = 0; h <= dw; h++) begin
        int last;
        last = (p == npts - 1 && h == dw) ? 1 : 0;
        check({tag, "_y"}, yo, y0 + p * stp);
        check({tag, "_x"}, xo, ex_x);
        check({tag, "_beam"}, bo, 1);
        check({tag, "_side"}, so, sd);
        check({tag, "_seg"}, sdo, last);
        check({tag, "_frame"}, fdo, last * sd);
        if (int'(yo) > max_y) max_y = int'(yo);
        if (c == poke_at) begin
          y_mid_l = 8'(nx_l);
          y_mid_r = 8'(nx_r);
          half_w  = 6'(nx_hw);
          dwell   = 4'(nx_dw);
          en      = nx_en[0];
        end
        c++;
        tick();
      end
    end
    check({tag, "_gap_beam"}, bo, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    y_mid_l = '0; y_mid_r = '0; half_w = '0; dwell = '0;
    tick();
    tick();
    chk_reset("rst");

    // Nominal frame
    y_mid_l = 8'd100; y_mid_r = 8'd150; half_w = 6'd21; dwell = 4'd0;
    en = 1'b1; rst = 1'b0;
    nx_l = 100; nx_r = 150; nx_hw = 21; nx_dw = 0; nx_en = 1;
    wait_beam("lat_l1", 2);
    seg("f1l", 0, 79, 42, 1, 0, 0, -1);
    wait_beam("lat_r1", 1);
    nx_l = 10; nx_r = 250;
    seg("f1r", 255, 129, 42, 1, 0, 1, 3);

    // Clamping; y_mid_l altered mid-segment must not disturb it
    wait_beam("lat_l2", 1);
    nx_l = 210;
    seg("f2l", 0, 0, 31, 1, 0, 0, 5);
    wait_beam("lat_r2", 1);
    seg("f2r", 255, 199, 21, 1, 0, 1, -1);
    wait_beam("lat_l3", 1);
    nx_r = 50; nx_hw = 0;
    seg("f3l", 0, 189, 31, 1, 0, 0, 2);

    // Degenerate single point, then dwell
    wait_beam("lat_r3", 1);
    nx_l = 100; nx_hw = 2; nx_dw = 3;
    seg("f3r", 255, 50, 1, 1, 0, 1, 0);
    wait_beam("lat_l4", 1);
    seg("f4l", 0, 98, 4, 1, 3, 0, -1);
    wait_beam("lat_r4", 1);
    nx_hw = 21; nx_dw = 0;
    seg("f4r", 255, 48, 4, 1, 3, 1, 0);

    // en dropped during the left segment
    wait_beam("lat_l5", 1);
    nx_en = 0;
    seg("f5l", 0, 79, 42, 1, 0, 0, 10);
    for (int i = 0; i < 5; i++) begin
      check("idle_beam", bo, 0);
      check("idle_side", so, 0);
      tick();
    end

    // Reset in the middle of a segment
    en = 1'b1;
    wait_beam("lat_idle", 2);
    for (int i = 0; i < 11; i++) tick();
    check("pre_rst_y", yo, 90);
    check("pre_rst_beam", bo, 1);
    rst = 1'b1;
    tick();
    chk_reset("rst_mid");
    rst = 1'b0;
    wait_beam("lat_rst", 2);
    check("post_rst_y", yo, 79);
    check("post_rst_x", xo, 0);
    check("post_rst_side", so, 0);

    // Y_STEP=2 instance
    sel = 1;
    rst = 1'b1;
    tick();
    chk_reset("rst_s2");
    rst = 1'b0;
    wait_beam("lat_s2", 2);
    seg("step2", 0, 79, 21, 2, 0, 0, -1);
    en = 1'b0;

    check("y_below_ymax", (max_y < 220) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
